// File: rtl/edge_map_writer_pkg.sv
// edge_map_writer_pkg: shared geometry, widths and FSM encoding for the edge-map writer
package edge_map_writer_pkg;
    localparam int IMG_W  = 256;
    localparam int IMG_H  = 256;
    localparam int ADDR_W = 13;
    localparam int CNT_W  = 17;
    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;
endpackage

// File: rtl/edge_byte_acc.sv
// edge_byte_acc: packs edge bits into one open byte and issues a registered write when it closes
module edge_byte_acc
    import edge_map_writer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_i,
    input  logic              flush_i,
    input  logic              dop_i,
    input  logic [2:0]        bit_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o
);
    logic [7:0]        acc_q, acc_d, base, wr_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_d;
    logic              open_q, open_d, new_byte, wr_en_d;

    always_comb begin
        new_byte  = acc_i && open_q && (addr_i != addr_q);
        // a freshly opened byte starts from zero so unwritten bits read as 0
        base      = (open_q && !new_byte) ? acc_q : 8'h00;
        acc_d     = acc_i ? ((base & ~(8'h01 << bit_i)) | (8'(dop_i) << bit_i)) : acc_q;
        addr_d    = acc_i ? addr_i : addr_q;
        open_d    = acc_i | (open_q & ~flush_i);
        wr_en_d   = new_byte | (flush_i & open_q);
        wr_addr_d = wr_en_d ? addr_q : wr_addr_o;
        wr_data_d = wr_en_d ? acc_q : wr_data_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            addr_q    <= '0;
            open_q    <= 1'b0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            acc_q     <= acc_d;
            addr_q    <= addr_d;
            open_q    <= open_d;
            wr_en_o   <= wr_en_d;
            wr_addr_o <= wr_addr_d;
            wr_data_o <= wr_data_d;
        end
    end
endmodule

// File: rtl/edge_map_writer.sv
// edge_map_writer: collects Sobel edge bits into bytes, writes them to the edge-map RAM,
// counts pixels and flags out-of-order input.
module edge_map_writer #(
    parameter int IMG_W = edge_map_writer_pkg::IMG_W,
    parameter int IMG_H = edge_map_writer_pkg::IMG_H
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        isReady,
    input  logic        Dop,
    input  logic [7:0]  Out_Row,
    input  logic [7:0]  Out_Column,
    input  logic        isEnd,
    output logic        Wr_En,
    output logic [12:0] Wr_Addr,
    output logic [7:0]  Wr_Data,
    output logic [16:0] Pix_Cnt,
    output logic        Done,
    output logic        Seq_Err
);
    import edge_map_writer_pkg::*;

    localparam logic [CNT_W-1:0] PIX_MAX = CNT_W'(IMG_W * IMG_H);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      prev_q, cur;
    logic             done_q, seq_q, have_prev_q, accept, flush;

    assign cur     = {Out_Row, Out_Column};
    assign accept  = Enable && isReady && (state_q == IDLE || state_q == COLLECT);
    // the open byte is written at the FLUSH edge, so it appears together with Done
    assign flush   = Enable && (state_q == FLUSH);
    assign Pix_Cnt = cnt_q;
    assign Done    = done_q;
    assign Seq_Err = seq_q;

    edge_byte_acc u_acc (
        .clk       (Clk),
        .rst       (Reset),
        .acc_i     (accept),
        .flush_i   (flush),
        .dop_i     (Dop),
        .bit_i     (Out_Column[2:0]),
        .addr_i    ({Out_Row, Out_Column[7:3]}),
        .wr_en_o   (Wr_En),
        .wr_addr_o (Wr_Addr),
        .wr_data_o (Wr_Data)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            done_q      <= 1'b0;
            seq_q       <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q       <= (cnt_q == PIX_MAX) ? cnt_q : cnt_q + 1'b1;
                seq_q       <= seq_q | (have_prev_q && (cur <= prev_q));
                prev_q      <= cur;
                have_prev_q <= 1'b1;
            end
            if (Enable) begin
                case (state_q)
                    IDLE:    state_q <= isEnd ? FLUSH : (isReady ? COLLECT : IDLE);
                    COLLECT: state_q <= isEnd ? FLUSH : COLLECT;
                    FLUSH: begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= DONE;
                endcase
            end
        end
    end
endmodule

// File: doc/edge_map_writer.md
EDGE_MAP_WRITER -- requirements
Module: edge_map_writer

Interface
REQ-001 The module SHALL have parameter IMG_W, default 256, meaning the image width in pixels (power of two, at least 8).
REQ-002 The module SHALL have parameter IMG_H, default 256, meaning the image height in pixels.
REQ-003 Clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Reset  input  1  reset; synchronous and active-high.
REQ-005 Enable  input  1  when low, the block SHALL accept no pixels and SHALL hold all state.
REQ-006 isReady  input  1  pixel valid strobe from the Sobel Datapath.
REQ-007 Dop  input  1  edge bit for the current pixel (1 = edge).
REQ-008 Out_Row  input  8  row of the current pixel.
REQ-009 Out_Column  input  8  column of the current pixel.
REQ-010 isEnd  input  1  last-pixel indication from the Datapath.
REQ-011 Wr_En  output  1  one-cycle write strobe to the edge-map RAM.
REQ-012 Wr_Addr  output  13  byte address, equal to {row, column[7:3]}.
REQ-013 Wr_Data  output  8  packed edge byte; bit k SHALL hold the pixel whose column[2:0] = k.
REQ-014 Pix_Cnt  output  17  number of pixels accepted since reset.
REQ-015 Done  output  1  frame complete; sticky.
REQ-016 Seq_Err  output  1  out-of-order pixel detected; sticky.

Function
REQ-017 A pixel SHALL be accepted in a cycle where Enable=1, isReady=1 and the state is COLLECT or IDLE.
REQ-018 FSM states: IDLE, COLLECT, FLUSH, DONE. Transitions:
- IDLE -> COLLECT on the first accepted pixel.
- COLLECT -> FLUSH when isEnd=1 is sampled with an accepted pixel, or with Enable=1 and no pixel.
- FLUSH -> DONE after exactly one cycle.
- DONE is left only by Reset.
REQ-019 The block SHALL hold one open byte: an accumulator plus its address. Unwritten bits SHALL be 0.
REQ-020 Accepted pixel, same byte address as the open byte: the block SHALL set the accumulator bit column[2:0] to Dop and SHALL NOT write.
REQ-021 Accepted pixel, different byte address: the block SHALL drive Wr_En=1 in the next cycle with the old address and data. The new byte SHALL then open containing only this pixel's bit.
REQ-022 In FLUSH the block SHALL write the open byte, including all pixel updates up to and including the isEnd cycle. Done SHALL rise in the following cycle.
REQ-023 At most one write SHALL occur per cycle. Write latency SHALL be exactly one cycle after the closing event.
REQ-024 An accepted pixel whose {row, column} is not greater than the previous accepted pixel's SHALL set Seq_Err. That pixel SHALL still be packed normally.
REQ-025 Pix_Cnt SHALL increment by 1 per accepted pixel and SHALL saturate at IMG_W*IMG_H.
REQ-026 isReady in FLUSH or DONE SHALL be ignored: no accept, no count, no write.
REQ-027 When isEnd=1 arrives in IDLE, the FSM SHALL go to DONE via FLUSH with no write, because no byte is open.
REQ-028 When Enable is low mid-frame, the open byte SHALL be retained unchanged.

Reset
REQ-029 When Reset is high at a clock edge, the state SHALL become IDLE and all of the following SHALL be 0: Wr_En, Wr_Addr, Wr_Data, Pix_Cnt, Done, Seq_Err, the accumulator and the open address.
REQ-030 Reset SHALL take priority over all other inputs, including an in-progress FLUSH. A write pending at that edge SHALL be dropped.

Structure
REQ-031 The shared package SHALL hold IMG_W, IMG_H, the address width (13), the count width (17) and the FSM state encoding.
REQ-032 The bit accumulator and open-address register SHALL be one sub-module, edge_byte_acc; the FSM, sequence check and counter SHALL stay in the top.

Verification
REQ-033 Scenario 1: pixels (0,0)..(0,7) with Dop=1,0,1,0,1,0,1,0, then (0,8) -> one write, Addr=0x0000, Data=0x55, one cycle after (0,8) is accepted.
REQ-034 Scenario 2: pixels (1,1)..(1,6) all with Dop=1, then pixel (1,8) -> write Addr=0x0020, Data=0x7E.
REQ-035 Scenario 3: full 256x256 frame from Matrix_binary.txt, isEnd on (255,255) -> 8192 writes, Pix_Cnt=65536, Done=1, Seq_Err=0, and memory contents match output.txt bit-for-bit.
REQ-036 Scenario 4: pixel (5,10) followed by (5,9) -> Seq_Err=1 and it stays 1 until Reset.
REQ-037 Scenario 5: Reset asserted during the FLUSH cycle -> no Wr_En, Done=0, Pix_Cnt=0 in the next cycle.
REQ-038 Scenario 6: Enable low for 3 cycles in mid-byte with isReady=1 -> no accept, no count change, and the byte is later written intact.
